// File: rtl/mips_pkg.sv
// Shared widths, ALU encodings and execute-stage FSM states for the 16-bit MIPS-like core.
package mips_pkg;

    localparam int XLEN      = 16;
    localparam int REG_AW    = 3;
    localparam int MUL_CNT_W = 4;

    localparam logic [MUL_CNT_W-1:0] MUL_LAST = 4'd15;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_PASSB = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_SLT = 3'b100,
        FN_MUL = 3'b101
    } funct_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } ex_state_e;

    function automatic logic is_mul_op(input logic [1:0] aluop, input logic [2:0] funct);
        return (aluop == ALUOP_RTYPE) && (funct == FN_MUL);
    endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU; multiply is handled by the iterative unit in execute_stage,
// so the mul function code produces 0 here.
module alu16
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [1:0]      i_aluop,
    input  logic [2:0]      i_funct,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_slt;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_slt  = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_result = '0;
        case (i_aluop)
            ALUOP_ADD:   o_result = w_sum;
            ALUOP_SUB:   o_result = w_diff;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_result = w_sum;
                    FN_SUB:  o_result = w_diff;
                    FN_AND:  o_result = i_a & i_b;
                    FN_OR:   o_result = i_a | i_b;
                    FN_SLT:  o_result = {{(XLEN-1){1'b0}}, w_slt};
                    default: o_result = '0;
                endcase
            end
            ALUOP_PASSB: o_result = i_b;
            default:     o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX and EX/MEM pipeline registers around alu16, plus a
// 16-iteration shift-add multiplier that stalls upstream while it runs.
module execute_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [XLEN-1:0]   PC_plus_two,
    input  logic [XLEN-1:0]   read_data_1,
    input  logic [XLEN-1:0]   read_data_2,
    input  logic [XLEN-1:0]   immediate,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [2:0]        funct,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic [1:0]        ALUOp,
    output logic              stall,
    output logic              out_valid,
    output logic [XLEN-1:0]   alu_result,
    output logic [XLEN-1:0]   store_data,
    output logic [REG_AW-1:0] write_register,
    output logic              O_RegWrite,
    output logic              O_MemtoReg,
    output logic              O_MemRead,
    output logic              O_MemWrite,
    output logic [XLEN-1:0]   branch_target,
    output logic              PC_Src
);

    ex_state_e r_state;
    ex_state_e w_state_next;

    logic [MUL_CNT_W-1:0] r_count;
    logic [XLEN-1:0]      r_mcand;
    logic [XLEN-1:0]      r_mplier;
    logic [XLEN-1:0]      r_prod;
    logic [XLEN-1:0]      w_prod_next;

    logic              r_idex_valid;
    logic [XLEN-1:0]   r_idex_pc2;
    logic [XLEN-1:0]   r_idex_rd1;
    logic [XLEN-1:0]   r_idex_rd2;
    logic [XLEN-1:0]   r_idex_opb;
    logic [XLEN-1:0]   r_idex_imm;
    logic [REG_AW-1:0] r_idex_wreg;
    logic [2:0]        r_idex_funct;
    logic [1:0]        r_idex_aluop;
    logic              r_idex_regwrite;
    logic              r_idex_memtoreg;
    logic              r_idex_memread;
    logic              r_idex_memwrite;
    logic              r_idex_branch;

    logic            w_capture;
    logic            w_in_mul;
    logic [XLEN-1:0] w_in_opb;
    logic            w_mul_last;
    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_zero;
    logic [XLEN-1:0] w_branch_target;

    assign stall           = (r_state == S_MUL);
    assign w_capture       = in_valid && !stall && !flush;
    assign w_in_mul        = is_mul_op(ALUOp, funct);
    assign w_in_opb        = ALUSrc ? immediate : read_data_2;
    assign w_mul_last      = (r_state == S_MUL) && (r_count == MUL_LAST);
    assign w_prod_next     = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_branch_target = r_idex_pc2 + {r_idex_imm[XLEN-2:0], 1'b0};

    alu16 u_alu (
        .i_a      (r_idex_rd1),
        .i_b      (r_idex_opb),
        .i_aluop  (r_idex_aluop),
        .i_funct  (r_idex_funct),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_capture && w_in_mul) w_state_next = S_MUL;
            S_MUL:   if (flush || r_count == MUL_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A multiply holds its ID/EX entry until the last iteration so the
    // destination and controls are still there when the product is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idex_valid    <= 1'b0;
            r_idex_pc2      <= '0;
            r_idex_rd1      <= '0;
            r_idex_rd2      <= '0;
            r_idex_opb      <= '0;
            r_idex_imm      <= '0;
            r_idex_wreg     <= '0;
            r_idex_funct    <= '0;
            r_idex_aluop    <= '0;
            r_idex_regwrite <= 1'b0;
            r_idex_memtoreg <= 1'b0;
            r_idex_memread  <= 1'b0;
            r_idex_memwrite <= 1'b0;
            r_idex_branch   <= 1'b0;
        end else if (w_capture) begin
            r_idex_valid    <= 1'b1;
            r_idex_pc2      <= PC_plus_two;
            r_idex_rd1      <= read_data_1;
            r_idex_rd2      <= read_data_2;
            r_idex_opb      <= w_in_opb;
            r_idex_imm      <= immediate;
            r_idex_wreg     <= RegDst ? rd : rt;
            r_idex_funct    <= funct;
            r_idex_aluop    <= ALUOp;
            r_idex_regwrite <= RegWrite;
            r_idex_memtoreg <= MemtoReg;
            r_idex_memread  <= MemRead;
            r_idex_memwrite <= MemWrite;
            r_idex_branch   <= Branch;
        end else if (flush || r_state == S_IDLE || w_mul_last) begin
            r_idex_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (r_state == S_IDLE) begin
            r_count <= '0;
            if (w_capture && w_in_mul) begin
                r_mcand  <= read_data_1;
                r_mplier <= w_in_opb;
                r_prod   <= '0;
            end
        end else begin
            r_count  <= (flush || w_mul_last) ? '0 : r_count + 4'd1;
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            alu_result     <= '0;
            store_data     <= '0;
            write_register <= '0;
            O_RegWrite     <= 1'b0;
            O_MemtoReg     <= 1'b0;
            O_MemRead      <= 1'b0;
            O_MemWrite     <= 1'b0;
            branch_target  <= '0;
            PC_Src         <= 1'b0;
        end else if (!flush && ((r_state == S_IDLE && r_idex_valid) || w_mul_last)) begin
            out_valid      <= 1'b1;
            alu_result     <= w_mul_last ? w_prod_next : w_alu_result;
            store_data     <= r_idex_rd2;
            write_register <= r_idex_wreg;
            O_RegWrite     <= r_idex_regwrite;
            O_MemtoReg     <= r_idex_memtoreg;
            O_MemRead      <= r_idex_memread;
            O_MemWrite     <= r_idex_memwrite;
            branch_target  <= w_branch_target;
            PC_Src         <= !w_mul_last && r_idex_branch && w_alu_zero;
        end else begin
            out_valid  <= 1'b0;
            O_RegWrite <= 1'b0;
            O_MemtoReg <= 1'b0;
            O_MemRead  <= 1'b0;
            O_MemWrite <= 1'b0;
            PC_Src     <= 1'b0;
        end
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL: clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL: in_valid, input, 1, decoded instruction present on inputs this cycle.
REQ-004 SHALL: flush, input, 1, kill the captured or in-flight instruction (taken branch).
REQ-005 SHALL: PC_plus_two, input, 16, PC of the instruction plus 2.
REQ-006 SHALL: read_data_1 / read_data_2, input, 16 each, register operands.
REQ-007 SHALL: immediate, input, 16, sign-extended immediate.
REQ-008 SHALL: rt / rd, input, 3 each, destination candidates.
REQ-009 SHALL: funct, input, 3, R-type function code.
REQ-010 SHALL: RegDst, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch, input, 1 each, decode controls.
REQ-011 SHALL: ALUOp, input, 2, ALU class.
REQ-012 SHALL: stall, output, 1, upstream holds its inputs while high.
REQ-013 SHALL: out_valid, output, 1, EX/MEM register holds a live instruction.
REQ-014 SHALL: alu_result, output, 16, ALU or multiply result.
REQ-015 SHALL: store_data, output, 16, registered read_data_2.
REQ-016 SHALL: write_register, output, 3, selected destination (RegDst ? rd : rt).
REQ-017 SHALL: O_RegWrite, O_MemtoReg, O_MemRead, O_MemWrite, output, 1 each, forwarded controls.
REQ-018 SHALL: branch_target, output, 16, PC_plus_two + (immediate << 1), mod 2^16.
REQ-019 SHALL: PC_Src, output, 1, Branch AND zero, qualified by out_valid.

Function
REQ-020 SHALL: ID/EX capture on the edge where in_valid=1, stall=0, flush=0; otherwise the register holds or becomes a bubble.
REQ-021 SHALL: single-cycle op captured at edge N reaches the EX/MEM outputs at edge N+1.
REQ-022 SHALL: ALUOp encoding: 00 = add (lw/sw), 01 = sub (beq, zero = result==0), 10 = R-type by funct, 11 = pass operand B.
REQ-023 SHALL: funct encoding: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 0/1), 101 mul, 110-111 result 0; add/sub wrap mod 2^16, no overflow flag.
REQ-024 SHALL: operand B = ALUSrc ? immediate : read_data_2.
REQ-025 SHALL: FSM states are IDLE and MUL; mul capture at edge N enters MUL with counter=0, then one shift-add iteration per edge over N+1..N+16.
REQ-026 SHALL: at the iteration where counter=15, return to IDLE and load the EX/MEM register; the low 16 bits of the product are valid after edge N+16.
REQ-027 SHALL: stall = (state==MUL); in_valid is ignored while stall is high.
REQ-028 SHALL: EX/MEM outputs read as a bubble while in MUL or when no capture occurred: out_valid, O_* controls and PC_Src are 0, data outputs are don't-care.
REQ-029 SHALL: flush has priority over in_valid; flush during MUL aborts to IDLE with no output and stall deasserts the next cycle.
REQ-030 SHALL: PC_Src is high for exactly one cycle per taken branch.

Reset
REQ-031 SHALL: with rst_n=0 at an edge, the FSM goes to IDLE, counter to 0, and every output to 0 (stall included), aborting any multiply.

Structure
REQ-032 SHALL: mips_pkg holds XLEN=16, REG_AW=3, the ALUOp and funct encodings, and the FSM state enum.
REQ-033 SHALL: the combinational ALU is sub-module alu16; the multiplier FSM and the ID/EX and EX/MEM registers live in execute_stage.

Verification
REQ-034 SHALL: R-type add, rd1=0x7FFF, rd2=0x0001 -> next cycle alu_result=0x8000, out_valid=1.
REQ-035 SHALL: slt with rd1=0xFFFF, rd2=0x0001 -> alu_result=0x0001.
REQ-036 SHALL: mul 0x0123 x 0x0010 -> stall high 16 cycles, alu_result=0x1230 at edge N+16, in_valid held meanwhile ignored.
REQ-037 SHALL: beq with rd1=rd2=5, PC_plus_two=0x0010, imm=0xFFFE -> branch_target=0x000C, PC_Src=1 for one cycle.
REQ-038 SHALL: flush at the 5th MUL cycle -> no out_valid, stall=0 next cycle; the next add completes normally.
REQ-039 SHALL: rst_n=0 mid-multiply -> all outputs 0 next edge, state IDLE.
